// File: rtl/div_pkg.sv
// Shared types, constants and sign helpers for the divide sequencing controller.
// Combinational helpers only. No latency and no backpressure of their own.
package div_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DRAIN,
    RESP
  } div_state_e;

  // Bit 0 of the opcode marks the unsigned variants.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  // The most negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? ('0 - x) : x;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

endpackage

// File: rtl/divider.sv
// Unsigned restoring divider. Takes one bit per cycle, so done_o is high 33 cycles after start_i.
// It has no backpressure: results are valid only while done_o is high. start_i must not be pulsed while it is busy.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    trial  = {rem_q, quo_q[XLEN-1]};
    diff   = trial - {1'b0, dvs_q};
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(XLEN);
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        // If diff[XLEN] is set, the trial subtraction went negative and the partial remainder is kept.
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU/REM/REMU through the divider. Fast paths and cache hits respond in 1 cycle; a divider pass responds in 35 cycles.
// Accepts one request at a time and holds the response until resp_ready_i is seen. A flush discards work that is in flight.
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = div_pkg::XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_opr1_i,
  input  logic [XLEN-1:0]  req_opr2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  opr1_q, opr1_d;
  logic [XLEN-1:0]  opr2_q, opr2_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             cache_vld_q, cache_vld_d;
  logic             cache_sgn_q, cache_sgn_d;
  logic [XLEN-1:0]  cache_opr1_q, cache_opr1_d;
  logic [XLEN-1:0]  cache_opr2_q, cache_opr2_d;
  logic [XLEN-1:0]  cache_quo_q, cache_quo_d;
  logic [XLEN-1:0]  cache_rem_q, cache_rem_d;

  logic            accept, req_sgn, req_ovf, cache_hit, op_sgn;
  logic            div_start, div_done;
  logic [XLEN-1:0] dvd_mag, dvs_mag, div_quo, div_rem, quo_fix, rem_fix;

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_sgn     = op_is_signed(req_op_i);
  assign req_ovf     = req_sgn && (req_opr1_i == DIV_OVF_DIVIDEND) && (req_opr2_i == '1);
  assign cache_hit   = cache_vld_q && (req_opr1_i == cache_opr1_q) &&
                       (req_opr2_i == cache_opr2_q) && (req_sgn == cache_sgn_q);

  // The divider sees magnitudes only; the signs are put back from the stored operands.
  assign op_sgn  = op_is_signed(op_q);
  assign dvd_mag = abs_val(opr1_q, op_sgn);
  assign dvs_mag = abs_val(opr2_q, op_sgn);
  assign quo_fix = neg_if(div_quo, op_sgn && (opr1_q[XLEN-1] ^ opr2_q[XLEN-1]));
  assign rem_fix = neg_if(div_rem, op_sgn && opr1_q[XLEN-1]);

  divider #(.XLEN(XLEN)) u_divider (
    .clk         (clk),
    .rst_n       (rst),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    opr1_d       = opr1_q;
    opr2_d       = opr2_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    cache_vld_d  = cache_vld_q;
    cache_sgn_d  = cache_sgn_q;
    cache_opr1_d = cache_opr1_q;
    cache_opr2_d = cache_opr2_q;
    cache_quo_d  = cache_quo_q;
    cache_rem_d  = cache_rem_q;
    div_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = div_op_e'(req_op_i);
          tag_d      = req_tag_i;
          opr1_d     = req_opr1_i;
          opr2_d     = req_opr2_i;
          resp_tag_d = req_tag_i;
          state_d    = RESP;
          if (req_opr2_i == '0) begin
            resp_data_d = op_is_rem(req_op_i) ? req_opr1_i : '1;
          end else if (req_ovf) begin
            resp_data_d = op_is_rem(req_op_i) ? '0 : DIV_OVF_DIVIDEND;
          end else if (cache_hit) begin
            resp_data_d = op_is_rem(req_op_i) ? cache_rem_q : cache_quo_q;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        div_start = 1'b1;
        if (flush_i) begin
          cache_vld_d = 1'b0;
          state_d     = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          cache_vld_d = 1'b0;
          // If done coincides with the flush, there is nothing left to drain.
          state_d     = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          resp_data_d  = op_is_rem(op_q) ? rem_fix : quo_fix;
          resp_tag_d   = tag_q;
          cache_vld_d  = 1'b1;
          cache_sgn_d  = op_sgn;
          cache_opr1_d = opr1_q;
          cache_opr2_d = opr2_q;
          cache_quo_d  = quo_fix;
          cache_rem_d  = rem_fix;
          state_d      = RESP;
        end
      end
      DRAIN: begin
        if (div_done) state_d = IDLE;
      end
      RESP: begin
        if (resp_ready_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= DIV;
      tag_q        <= '0;
      opr1_q       <= '0;
      opr2_q       <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      cache_vld_q  <= 1'b0;
      cache_sgn_q  <= 1'b0;
      cache_opr1_q <= '0;
      cache_opr2_q <= '0;
      cache_quo_q  <= '0;
      cache_rem_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      opr1_q       <= opr1_d;
      opr2_q       <= opr2_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      cache_vld_q  <= cache_vld_d;
      cache_sgn_q  <= cache_sgn_d;
      cache_opr1_q <= cache_opr1_d;
      cache_opr2_q <= cache_opr2_d;
      cache_quo_q  <= cache_quo_d;
      cache_rem_q  <= cache_rem_d;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_tag_o   = resp_tag_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, fast paths, cache hits, stalls, flushes and asynchronous reset.
module tb_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'b00;
  logic [31:0] req_opr1_i = '0;
  logic [31:0] req_opr2_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_opr1_i   (req_opr1_i),
    .req_opr2_i   (req_opr2_i),
    .req_tag_i    (req_tag_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_tag_o   (resp_tag_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.div_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, then returns in the first cycle with resp_valid_o high (or at the bound).
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output int lat);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_opr1_i  = a;
    req_opr2_i  = b;
    req_tag_i   = t;
    step();
    req_valid_i = 1'b0;
    lat = 1;
    while (resp_valid_o !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
  endtask

  initial begin
    int lat, s0, cyc, bad;
    logic saw;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_data", resp_data_o, 32'd0);
    chk("rst_tag", 32'(resp_tag_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    rst = 1'b1;
    step();

    s0 = start_cnt;
    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, lat);
    chk("div_lat", 32'(lat), 32'd35);
    chk("div_data", resp_data_o, 32'hFFFF_FFFD);
    chk("div_tag", 32'(resp_tag_o), 32'd3);
    chk("div_starts", 32'(start_cnt - s0), 32'd1);
    handshake();
    chk("div_idle", 32'(busy_o), 32'd0);

    s0 = start_cnt;
    do_req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, lat);
    chk("rem_hit_lat", 32'(lat), 32'd1);
    chk("rem_hit_data", resp_data_o, 32'hFFFF_FFFF);
    chk("rem_hit_tag", 32'(resp_tag_o), 32'd4);
    handshake();

    do_req(OP_DIVU, 32'd100, 32'd0, 5'd5, lat);
    chk("divz_lat", 32'(lat), 32'd1);
    chk("divz_data", resp_data_o, 32'hFFFF_FFFF);
    handshake();
    do_req(OP_REMU, 32'd100, 32'd0, 5'd6, lat);
    chk("remz_lat", 32'(lat), 32'd1);
    chk("remz_data", resp_data_o, 32'd100);
    handshake();

    do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, lat);
    chk("ovf_div_lat", 32'(lat), 32'd1);
    chk("ovf_div_data", resp_data_o, 32'h8000_0000);
    handshake();
    do_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat);
    chk("ovf_rem_lat", 32'(lat), 32'd1);
    chk("ovf_rem_data", resp_data_o, 32'd0);
    handshake();
    chk("fast_no_start", 32'(start_cnt - s0), 32'd0);

    do_req(OP_DIVU, 32'd1000, 32'd7, 5'd9, lat);
    chk("stall_lat", 32'(lat), 32'd35);
    bad = 0;
    repeat (10) begin
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'd142 ||
          resp_tag_o !== 5'd9 || req_ready_o !== 1'b0) bad++;
      step();
    end
    chk("stall_hold", 32'(bad), 32'd0);
    chk("stall_data", resp_data_o, 32'd142);
    handshake();
    chk("stall_idle", 32'(busy_o), 32'd0);
    do_req(OP_REMU, 32'd1000, 32'd7, 5'd10, lat);
    chk("remu_hit_lat", 32'(lat), 32'd1);
    chk("remu_hit_data", resp_data_o, 32'd6);
    handshake();

    s0 = start_cnt;
    req_valid_i = 1'b1;
    req_op_i    = OP_DIVU;
    req_opr1_i  = 32'd50;
    req_opr2_i  = 32'd5;
    req_tag_i   = 5'd11;
    step();
    req_valid_i = 1'b0;
    repeat (10) step();
    chk("wait_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    cyc = 12;
    saw = 1'b0;
    while (busy_o === 1'b1 && cyc < 80) begin
      if (resp_valid_o === 1'b1) saw = 1'b1;
      if (req_ready_o !== 1'b0) saw = 1'b1;
      step();
      cyc++;
    end
    chk("drain_len", 32'(cyc), 32'd35);
    chk("drain_no_resp", 32'(saw), 32'd0);
    chk("drain_starts", 32'(start_cnt - s0), 32'd1);

    do_req(OP_DIVU, 32'd1000, 32'd7, 5'd12, lat);
    chk("inval_lat", 32'(lat), 32'd35);
    chk("inval_data", resp_data_o, 32'd142);
    handshake();
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd13, lat);
    chk("post_flush_lat", 32'(lat), 32'd35);
    chk("post_flush_data", resp_data_o, 32'd3);
    handshake();

    do_req(OP_REMU, 32'd9, 32'd3, 5'd14, lat);
    chk("resp_flush_lat", 32'(lat), 32'd1);
    chk("resp_flush_data", resp_data_o, 32'd0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("resp_flush_valid", 32'(resp_valid_o), 32'd0);
    chk("resp_flush_busy", 32'(busy_o), 32'd0);
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd15, lat);
    chk("kept_cache_lat", 32'(lat), 32'd1);
    chk("kept_cache_data", resp_data_o, 32'd3);
    handshake();

    req_valid_i = 1'b1;
    req_op_i    = OP_DIVU;
    req_opr1_i  = 32'd20;
    req_opr2_i  = 32'd4;
    flush_i     = 1'b1;
    #1;
    chk("idle_flush_ready", 32'(req_ready_o), 32'd0);
    step();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    chk("idle_flush_busy", 32'(busy_o), 32'd0);

    req_valid_i = 1'b1;
    req_op_i    = OP_DIVU;
    req_opr1_i  = 32'd15;
    req_opr2_i  = 32'd4;
    req_tag_i   = 5'd16;
    step();
    req_valid_i = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid_o), 32'd0);
    chk("arst_data", resp_data_o, 32'd0);
    chk("arst_tag", 32'(resp_tag_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    step();
    do_req(OP_DIVU, 32'd15, 32'd4, 5'd17, lat);
    chk("post_rst_lat", 32'(lat), 32'd35);
    chk("post_rst_data", resp_data_o, 32'd3);
    chk("post_rst_tag", 32'(resp_tag_o), 32'd17);
    handshake();
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd18, lat);
    chk("rst_inval_lat", 32'(lat), 32'd35);
    chk("rst_inval_data", resp_data_o, 32'd3);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
